truth_table_sweeper: RTL and testbench

//  Synthesisable stimulus/capture stage wrapped around a 5-input combinational block.

---
 rtl/truth_table_sweeper_pkg.sv | 19 +
 rtl/truth_table_sweeper_settle_timer.sv | 32 +++
 rtl/truth_table_sweeper.sv | 100 ++++++++++
 tb/tb_truth_table_sweeper.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and defaults for the truth-table sweeper.
package truth_table_sweeper_pkg;

  localparam int unsigned DefNIn   = 5;
  localparam int unsigned DefSettle = 2;

  // Sweep controller states
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Width of the settle counter; at least one bit even when SETTLE == 1
  function automatic int unsigned cnt_width(input int unsigned settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle timer: counts 0..SETTLE-1 while enabled and flags the last cycle of each hold.
module settle_timer
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned SETTLE = DefSettle
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int unsigned CW = cnt_width(SETTLE);
  localparam logic [CW-1:0] LastVal = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_q;

  assign last = (cnt_q == LastVal);

  // Counter wraps to 0 after the last cycle so consecutive vectors need no explicit clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= last ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives every input vector of a combinational block, holds each one
// for SETTLE cycles, and captures the block's output into a truth table and a ones-count.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned N_IN   = DefNIn,
  parameter int unsigned SETTLE = DefSettle
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 z_in,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        ones_cnt
);

  localparam logic [N_IN-1:0] LastIdx = '1;

  state_e          state_q;
  logic [N_IN-1:0] idx_q;
  logic            timer_clear;
  logic            timer_en;
  logic            settle_last;

  // Timer idles at 0 outside DRIVE, so it is already cleared when a sweep is accepted
  assign timer_clear = (state_q != StDrive) | abort;
  assign timer_en    = (state_q == StDrive);

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .last   (settle_last)
  );

  // Sweep FSM with registered outputs; abort takes priority over everything but reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      vec       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
      ones_cnt  <= '0;
    end else if (abort) begin
      // Any sample strobed this cycle is dropped; captured bits are kept
      state_q <= StIdle;
      idx_q   <= '0;
      vec     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            table_out <= '0;
            ones_cnt  <= '0;
            idx_q     <= '0;
            vec       <= '0;
            busy      <= 1'b1;
            state_q   <= StDrive;
          end
        end
        StDrive: begin
          if (settle_last) begin
            table_out[idx_q] <= z_in;
            ones_cnt         <= ones_cnt + (N_IN + 1)'(z_in);
            if (idx_q == LastIdx) begin
              state_q <= StDone;
              done    <= 1'b1;
              busy    <= 1'b0;
              vec     <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
              vec   <= vec + 1'b1;
            end
          end
        end
        StDone: begin
          done    <= 1'b0;
          idx_q   <= '0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: three instances (SETTLE = 2, 1, 4) each paired
// with a selectable 5-input function of their own vec output.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic abort;
  int   zmode;

  logic [2:0]       z_a;
  logic [2:0][4:0]  vec_a;
  logic [2:0]       busy_a;
  logic [2:0]       done_a;
  logic [2:0][31:0] table_a;
  logic [2:0][5:0]  ones_a;

  int n_vec = 0;
  int n_err = 0;

  int lat[3];
  int vec_err[3];
  int dcount[3];
  int sv[3] = '{2, 1, 4};

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(5), .SETTLE(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .z_in(z_a[0]),
    .vec(vec_a[0]), .busy(busy_a[0]), .done(done_a[0]), .table_out(table_a[0]),
    .ones_cnt(ones_a[0])
  );
  truth_table_sweeper #(.N_IN(5), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .z_in(z_a[1]),
    .vec(vec_a[1]), .busy(busy_a[1]), .done(done_a[1]), .table_out(table_a[1]),
    .ones_cnt(ones_a[1])
  );
  truth_table_sweeper #(.N_IN(5), .SETTLE(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .z_in(z_a[2]),
    .vec(vec_a[2]), .busy(busy_a[2]), .done(done_a[2]), .table_out(table_a[2]),
    .ones_cnt(ones_a[2])
  );

  // Block under test: vec = {a,b,c,d,e}
  function automatic logic z_of(input int mode, input logic [4:0] v);
    logic a, b, c, d, e;
    {a, b, c, d, e} = v;
    case (mode)
      0:       return a;
      1:       return e;
      2:       return 1'b0;
      3:       return (a & b) | (c & d) | e;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_table(input int mode);
    logic [31:0] t;
    logic [4:0]  v;
    t = '0;
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      t[i] = z_of(mode, v);
    end
    return t;
  endfunction

  always_comb begin
    z_a = '0;
    for (int k = 0; k < 3; k++) z_a[k] = z_of(zmode, vec_a[k]);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, got, exp);
    end
  endtask

  // Start a sweep and watch all instances; optionally re-pulse start or abort when the
  // SETTLE=2 instance shows a given vec value
  task automatic sweep(input int mode, input int restart_at, input int abort_at);
    int         cyc;
    bit         restarted;
    bit         aborted;
    logic [4:0] prev[3];
    int         last_chg[3];
    zmode     = mode;
    restarted = 1'b0;
    aborted   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      lat[k] = 0; vec_err[k] = 0; dcount[k] = 0; prev[k] = '0; last_chg[k] = 1;
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    chk($sformatf("m%0d_clear_table", mode), 64'(table_a[0]), 64'h0);
    chk($sformatf("m%0d_clear_ones", mode), 64'(ones_a[0]), 64'h0);
    chk($sformatf("m%0d_busy", mode), 64'(busy_a[0]), 64'h1);
    while (cyc < 200 && !(lat[0] != 0 && lat[1] != 0 && lat[2] != 0)) begin
      for (int k = 0; k < 3; k++) begin
        if (done_a[k]) begin
          dcount[k]++;
          if (lat[k] == 0) lat[k] = cyc;
        end
        if (!aborted && vec_a[k] != prev[k]) begin
          if (cyc - last_chg[k] != sv[k]) vec_err[k]++;
          last_chg[k] = cyc;
          prev[k]     = vec_a[k];
        end
      end
      start = 1'b0;
      abort = 1'b0;
      if (restart_at >= 0 && !restarted && vec_a[0] == 5'(restart_at)) begin
        start = 1'b1; restarted = 1'b1;
      end
      if (abort_at >= 0 && !aborted && vec_a[0] == 5'(abort_at)) begin
        abort = 1'b1; aborted = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    abort = 1'b0;
    // Let any straggling done pulse show up in the count
    repeat (2) begin
      for (int k = 0; k < 3; k++) if (done_a[k]) dcount[k]++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    int          mode;
    logic [31:0] exp_table;
    logic [5:0]  exp_ones;
  } tvec_t;

  tvec_t tv[5];

  initial begin
    int w;
    tv[0] = '{0, 32'hFFFF_0000, 6'd16};  // z = a
    tv[1] = '{1, 32'hAAAA_AAAA, 6'd16};  // z = e
    tv[2] = '{2, 32'h0000_0000, 6'd0};   // z = 0
    tv[3] = '{3, 32'hFFEA_EAEA, 6'd23};  // z = ab | cd | e
    tv[4] = '{4, 32'hFFFF_FFFF, 6'd32};  // z = 1

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; zmode = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_vec", 64'(vec_a[0]), 64'h0);
    chk("rst_busy", 64'(busy_a[0]), 64'h0);
    chk("rst_done", 64'(done_a[0]), 64'h0);
    chk("rst_table", 64'(table_a[0]), 64'h0);
    chk("rst_ones", 64'(ones_a[0]), 64'h0);

    for (int i = 0; i < 5; i++) begin
      sweep(tv[i].mode, -1, -1);
      chk($sformatf("m%0d_table", tv[i].mode), 64'(table_a[0]), 64'(tv[i].exp_table));
      chk($sformatf("m%0d_ones", tv[i].mode), 64'(ones_a[0]), 64'(tv[i].exp_ones));
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("m%0d_s%0d_latency", tv[i].mode, sv[k]), 64'(lat[k]),
            64'(sv[k] * 32 + 1));
        chk($sformatf("m%0d_s%0d_model", tv[i].mode, sv[k]), 64'(table_a[k]),
            64'(model_table(tv[i].mode)));
        chk($sformatf("m%0d_s%0d_vec_hold", tv[i].mode, sv[k]), 64'(vec_err[k]), 64'h0);
        chk($sformatf("m%0d_s%0d_done_pulses", tv[i].mode, sv[k]), 64'(dcount[k]), 64'h1);
      end
      chk($sformatf("m%0d_idle_busy", tv[i].mode), 64'(busy_a[0]), 64'h0);
      chk($sformatf("m%0d_idle_vec", tv[i].mode), 64'(vec_a[0]), 64'h0);
    end

    // Abort while vec == 5 with z = 1: bits 0..4 kept, no done
    sweep(4, -1, 5);
    chk("abort_no_done", 64'(dcount[0]), 64'h0);
    chk("abort_busy", 64'(busy_a[0]), 64'h0);
    chk("abort_vec", 64'(vec_a[0]), 64'h0);
    chk("abort_table", 64'(table_a[0]), 64'h0000_001F);
    chk("abort_ones", 64'(ones_a[0]), 64'd5);

    // Second start at vec == 10 is ignored
    sweep(0, 10, -1);
    chk("restart_latency", 64'(lat[0]), 64'd65);
    chk("restart_table", 64'(table_a[0]), 64'hFFFF_0000);
    chk("restart_ones", 64'(ones_a[0]), 64'd16);
    chk("restart_done_pulses", 64'(dcount[0]), 64'h1);
    // A fresh start clears the previous table (checked at cycle 1 inside sweep)
    sweep(2, -1, -1);
    chk("after_restart_table", 64'(table_a[0]), 64'h0);

    // Asynchronous reset at vec == 20
    zmode = 4;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    w = 0;
    while (vec_a[0] != 5'd20 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("rst_mid_reached_vec20", 64'(w < 200), 64'h1);
    chk("rst_mid_pre_table", 64'(table_a[0]), 64'h000F_FFFF);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_vec", 64'(vec_a[0]), 64'h0);
    chk("rst_mid_busy", 64'(busy_a[0]), 64'h0);
    chk("rst_mid_table", 64'(table_a[0]), 64'h0);
    chk("rst_mid_ones", 64'(ones_a[0]), 64'h0);
    chk("rst_mid_done", 64'(done_a[0]), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    w = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy_a[0] || done_a[0] || vec_a[0] != 5'd0) w++;
    end
    chk("rst_release_stays_idle", 64'(w), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
